// File: rtl/shift_wb_queue_pkg.sv
// Shared definitions for the shifter write-back path: result/register widths and
// the queued entry record used by the shifter, the write-back queue and the register file.
package shift_wb_queue_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] rd;
    logic              set_flags;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/shift_wb_queue_wb_fifo.sv
// Generic DEPTH-entry synchronous FIFO with flush, occupancy count and per-entry
// valid bits; storage is exposed so the owner can reduce over live entries.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [WIDTH-1:0]             push_data,
  output logic                         pop_valid,
  input  logic                         pop_ready,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         pop_fire,
  output logic [DEPTH-1:0]             ent_vld,
  output logic [DEPTH-1:0][WIDTH-1:0]  ent_data,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic                        push_fire;

  // A full queue refuses a push even if the head retires in the same cycle.
  assign push_ready = (count < FULL_CNT);
  assign pop_valid  = (count != '0);
  assign push_fire  = push_valid && push_ready && !flush;
  assign pop_fire   = pop_valid && pop_ready && !flush;
  assign pop_data   = pop_valid ? mem[rd_ptr] : '0;
  assign ent_data   = mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr          <= wr_ptr + PTR_W'(1);
        ent_vld[wr_ptr] <= 1'b1;
      end
      if (pop_fire) begin
        rd_ptr          <= rd_ptr + PTR_W'(1);
        ent_vld[rd_ptr] <= 1'b0;
      end
      unique case ({push_fire, pop_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; readers only look at entries whose valid bit is set.
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/shift_wb_queue.sv
// Write-back queue behind the arithmetic shifter: buffers results in order, drains them
// to the register-file write port, keeps the N/Z flags and publishes a pending-write mask.
module shift_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = shift_wb_queue_pkg::DATA_W,
  parameter int REG_AW = shift_wb_queue_pkg::REG_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [REG_AW-1:0]        in_rd,
  input  logic                     in_set_flags,
  input  logic                     flush,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [DATA_W-1:0]        wb_data,
  output logic [REG_AW-1:0]        wb_rd,
  output logic [(1<<REG_AW)-1:0]   pending,
  output logic                     flag_n,
  output logic                     flag_z,
  output logic [$clog2(DEPTH):0]   count
);

  // Entry layout matches the shared record: {data, rd, set_flags}.
  localparam int ENT_W = DATA_W + REG_AW + 1;

  logic [ENT_W-1:0]             push_ent;
  logic [ENT_W-1:0]             head_ent;
  logic [DEPTH-1:0]             ent_vld;
  logic [DEPTH-1:0][ENT_W-1:0]  ent_data;
  logic                         pop_fire;
  logic                         head_set_flags;

  assign push_ent = {in_data, in_rd, in_set_flags};

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (push_ent),
    .pop_valid  (wb_valid),
    .pop_ready  (wb_ready),
    .pop_data   (head_ent),
    .pop_fire   (pop_fire),
    .ent_vld    (ent_vld),
    .ent_data   (ent_data),
    .count      (count)
  );

  assign wb_data        = head_ent[ENT_W-1 -: DATA_W];
  assign wb_rd          = head_ent[REG_AW:1];
  assign head_set_flags = head_ent[0];

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) pending[ent_data[i][REG_AW:1]] = 1'b1;
    end
  end

  // Flags follow the retiring entry on the same edge that removes it from the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
    end else if (pop_fire && head_set_flags) begin
      flag_n <= wb_data[DATA_W-1];
      flag_z <= (wb_data == '0);
    end
  end

endmodule

// File: tb/tb_shift_wb_queue.sv
// Bench for shift_wb_queue: queue-based reference model, scoreboard monitor, directed
// scenarios followed by randomized traffic with occasional flush and reset.
module tb_shift_wb_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data = '0;
  logic [REG_AW-1:0]      in_rd = '0;
  logic                   in_set_flags = 1'b0;
  logic                   flush = 1'b0;
  logic                   wb_valid;
  logic                   wb_ready = 1'b0;
  logic [DATA_W-1:0]      wb_data;
  logic [REG_AW-1:0]      wb_rd;
  logic [(1<<REG_AW)-1:0] pending;
  logic                   flag_n;
  logic                   flag_z;
  logic [$clog2(DEPTH):0] count;

  shift_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rd(in_rd), .in_set_flags(in_set_flags), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .pending(pending), .flag_n(flag_n), .flag_z(flag_z), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] rd;
    logic              sf;
  } ent_t;

  ent_t mq[$];
  ent_t sb_q[$];
  logic mn = 1'b0;
  logic mz = 1'b0;
  int   checks = 0;
  int   passes = 0;

  function void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  function automatic logic [(1<<REG_AW)-1:0] model_pending();
    logic [(1<<REG_AW)-1:0] p = '0;
    foreach (mq[i]) p[mq[i].rd] = 1'b1;
    return p;
  endfunction

  // Reference model: ordered list of entries; occupancy is simply its length.
  always @(posedge clk or negedge rst_n) begin : model
    ent_t e;
    bit   do_push;
    bit   do_pop;
    if (!rst_n) begin
      mq.delete();
      sb_q.delete();
      mn = 1'b0;
      mz = 1'b0;
    end else if (flush) begin
      mq.delete();
      sb_q.delete();
    end else begin
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = wb_ready && (mq.size() > 0);
      if (do_pop) begin
        e = mq.pop_front();
        if (e.sf) begin
          mn = e.data[DATA_W-1];
          mz = (e.data == 0);
        end
      end
      if (do_push) begin
        e.data = in_data;
        e.rd   = in_rd;
        e.sf   = in_set_flags;
        mq.push_back(e);
        sb_q.push_back(e);
      end
    end
  end

  logic              hold_prev = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic [REG_AW-1:0] prev_rd;

  // Monitor: state checks every cycle, scoreboard pop on each write-back handshake.
  always @(negedge clk) begin : monitor
    ent_t e;
    chk("in_ready", in_ready, mq.size() < DEPTH);
    chk("wb_valid", wb_valid, mq.size() > 0);
    chk("count", count, mq.size());
    chk("pending", pending, model_pending());
    chk("flag_n", flag_n, mn);
    chk("flag_z", flag_z, mz);
    if (hold_prev && rst_n) begin
      chk("hold_data", wb_data, prev_data);
      chk("hold_rd", wb_rd, prev_rd);
    end
    hold_prev = rst_n && wb_valid && !wb_ready && !flush;
    prev_data = wb_data;
    prev_rd   = wb_rd;
    if (rst_n && wb_valid && wb_ready && !flush) begin
      if (sb_q.size() == 0) begin
        chk("sb_nonempty", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("wb_data", wb_data, e.data);
        chk("wb_rd", wb_rd, e.rd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, logic [DATA_W-1:0] d, logic [REG_AW-1:0] r, bit sf, bit rdy, bit fl);
    in_valid     = v;
    in_data      = d;
    in_rd        = r;
    in_set_flags = sf;
    wb_ready     = rdy;
    flush        = fl;
    tick();
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_pending", pending, 0);
    chk("rst_count", count, 0);
    chk("rst_flags", {flag_n, flag_z}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Negative result to r3, retire it
    drive(1, 32'h8000_0000, 4'd3, 1, 0, 0);
    #3;
    chk("p3_pending", pending, 16'h0008);
    chk("p3_wb_valid", wb_valid, 1);
    drive(0, 0, 0, 0, 1, 0);
    #3;
    chk("p3_flag_n", flag_n, 1);
    chk("p3_flag_z", flag_z, 0);
    chk("p3_pending_clr", pending, 0);

    // Five back-to-back pushes into a 4-deep queue, then drain in order
    for (int i = 0; i < 5; i++) drive(1, 32'h100 + i, 4'(i), 0, 0, 0);
    #3;
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 0);
    #3;
    chk("drained_count", count, 0);

    // Full queue with push and pop offered: pop only; then steady push+pop
    for (int i = 0; i < 4; i++) drive(1, 32'h200 + i, 4'(i + 4), 0, 0, 0);
    drive(1, 32'h2ff, 4'd15, 0, 1, 0);
    #3;
    chk("full_pop_only", count, 3);
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h300 + i, 4'(i), 1, 1, 0);
      #3;
      chk("steady_count", count, 3);
    end
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 0);

    // Zero result sets Z; a non-flag-setting result leaves flags alone
    drive(1, 32'h0, 4'd7, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    #3;
    chk("zero_flag_z", flag_z, 1);
    chk("zero_flag_n", flag_n, 0);
    drive(1, 32'h7, 4'd8, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    #3;
    chk("nosf_flag_z", flag_z, 1);
    chk("nosf_flag_n", flag_n, 0);

    // Flush with a concurrent push
    drive(1, 32'h11, 4'd1, 1, 0, 0);
    drive(1, 32'h22, 4'd2, 1, 0, 0);
    drive(1, 32'h33, 4'd2, 1, 0, 0);
    #3;
    chk("preflush_pending", pending, 16'h0006);
    drive(1, 32'h44, 4'd9, 1, 1, 1);
    #3;
    chk("flush_count", count, 0);
    chk("flush_wb_valid", wb_valid, 0);
    chk("flush_pending", pending, 0);
    chk("flush_flags", {flag_n, flag_z}, 2'b01);
    drive(0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [DATA_W-1:0] d;
      int sel;
      sel = $urandom_range(0, 3);
      d = (sel == 0) ? 32'h0 : (sel == 1) ? (32'h8000_0000 | $urandom) : $urandom;
      if (i == 700) begin
        drive(1, d, 4'($urandom), 1, 0, 0);
        rst_n = 1'b0;
        #3;
        chk("midrst_count", count, 0);
        chk("midrst_wb_valid", wb_valid, 0);
        chk("midrst_flags", {flag_n, flag_z}, 0);
        tick();
        rst_n = 1'b1;
      end
      drive($urandom_range(0, 3) != 0, d, 4'($urandom), 1'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
    end
    drive(0, 0, 0, 0, 1, 0);
    repeat (6) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
